// File: rtl/arf_sched_pkg.sv
// Shared types and constants for the ARF variance schedule controller:
// source-index encoding, schedule-row layout and controller states.
package arf_sched_pkg;

  localparam int NUM_NODES     = 28;
  localparam int NUM_SRC       = 38;
  localparam int NUM_IN        = 10;
  localparam int NUM_COEF      = 16;
  localparam int SRC_NODE_BASE = 10;
  localparam int SCHED_MUL     = 2;
  localparam int SCHED_ADD     = 2;

  typedef struct packed {
    logic       en;
    logic [4:0] dst;
    logic [5:0] src_a;
    logic [5:0] src_b;
  } unit_op_t;

  typedef struct packed {
    unit_op_t [SCHED_ADD-1:0] add;
    unit_op_t [SCHED_MUL-1:0] mul;
  } sched_row_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Node n (1..28) lives at source index SRC_NODE_BASE + n - 1
  function automatic int node_idx(input int n);
    return SRC_NODE_BASE + n - 1;
  endfunction

  function automatic unit_op_t mk_op(input int dst, input int src_a, input int src_b);
    unit_op_t op;
    op.en    = 1'b1;
    op.dst   = 5'(dst);
    op.src_a = 6'(src_a);
    op.src_b = 6'(src_b);
    return op;
  endfunction

endpackage

// File: rtl/arf_sched_rom.sv
// Combinational schedule ROM: maps a control step to the unit operations
// issued in that step. Rows past the last scheduled step are empty.
module arf_sched_rom
  import arf_sched_pkg::*;
#(
  parameter int STEP_W = 4
) (
  input  logic [STEP_W-1:0] step,
  output sched_row_t        row
);

  // Multiplier srcB fields index coef directly; all other sources use the
  // shared input/node index space.
  always_comb begin
    row = '0;
    case (int'(step))
      0: begin
        row.mul[0] = mk_op(1, 0, 0);
        row.mul[1] = mk_op(2, 1, 1);
      end
      1: begin
        row.mul[0] = mk_op(3, 2, 2);
        row.mul[1] = mk_op(4, 3, 3);
        row.add[0] = mk_op(9, node_idx(1), node_idx(2));
      end
      2: begin
        row.mul[0] = mk_op(5, 4, 4);
        row.mul[1] = mk_op(6, 5, 5);
        row.add[0] = mk_op(10, node_idx(3), node_idx(4));
        row.add[1] = mk_op(13, node_idx(9), 8);
      end
      3: begin
        row.mul[0] = mk_op(7, 6, 6);
        row.mul[1] = mk_op(8, 7, 7);
        row.add[0] = mk_op(11, node_idx(5), node_idx(6));
        row.add[1] = mk_op(14, node_idx(10), 9);
      end
      4: begin
        row.mul[0] = mk_op(15, node_idx(13), 8);
        row.mul[1] = mk_op(16, node_idx(13), 9);
        row.add[0] = mk_op(12, node_idx(7), node_idx(8));
      end
      5: begin
        row.mul[0] = mk_op(17, node_idx(14), 10);
        row.mul[1] = mk_op(18, node_idx(14), 11);
      end
      6: begin
        row.add[0] = mk_op(19, node_idx(15), node_idx(17));
        row.add[1] = mk_op(20, node_idx(16), node_idx(18));
      end
      7: begin
        row.mul[0] = mk_op(21, node_idx(19), 12);
        row.mul[1] = mk_op(22, node_idx(19), 13);
      end
      8: begin
        row.mul[0] = mk_op(23, node_idx(20), 14);
        row.mul[1] = mk_op(24, node_idx(20), 15);
      end
      9: begin
        row.add[0] = mk_op(25, node_idx(21), node_idx(23));
        row.add[1] = mk_op(26, node_idx(22), node_idx(24));
      end
      10: begin
        row.add[0] = mk_op(27, node_idx(25), node_idx(11));
        row.add[1] = mk_op(28, node_idx(26), node_idx(12));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arf_sched_ctrl.sv
// Static-schedule controller for the ARF variance graph: owns the node
// register file and drives the shared mul/add units one ROM row per cycle.
module arf_sched_ctrl
  import arf_sched_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_MUL   = 2,
  parameter int NUM_ADD   = 2,
  parameter int SCHED_LEN = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        hold,
  input  logic [NUM_IN*DATA_W-1:0]    in_data,
  input  logic [NUM_COEF*DATA_W-1:0]  coef,
  output logic [NUM_MUL*DATA_W-1:0]   mul_a,
  output logic [NUM_MUL*DATA_W-1:0]   mul_b,
  input  logic [NUM_MUL*DATA_W-1:0]   mul_res,
  output logic [NUM_ADD*DATA_W-1:0]   add_a,
  output logic [NUM_ADD*DATA_W-1:0]   add_b,
  input  logic [NUM_ADD*DATA_W-1:0]   add_res,
  output logic [DATA_W-1:0]           out_27,
  output logic [DATA_W-1:0]           out_28,
  output logic                        busy,
  output logic                        done
);

  localparam int STEP_W = (SCHED_LEN > 1) ? $clog2(SCHED_LEN) : 1;

  state_t                      state_q, state_d;
  logic [STEP_W-1:0]           step_q;
  logic [NUM_IN*DATA_W-1:0]    in_q;
  logic [DATA_W-1:0]           node_q [1:NUM_NODES];
  logic [DATA_W-1:0]           node_d [1:NUM_NODES];
  logic [DATA_W-1:0]           src_val [64];
  logic [DATA_W-1:0]           coef_val [64];
  sched_row_t                  row;
  logic                        run_adv;
  logic                        last_step;

  arf_sched_rom #(.STEP_W(STEP_W)) u_rom (
    .step (step_q),
    .row  (row)
  );

  assign run_adv   = (state_q == RUN) && !hold;
  assign last_step = (step_q == STEP_W'(SCHED_LEN - 1));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (!hold && last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flatten latched inputs and nodes into one index space; unused codes read 0
  always_comb begin
    for (int i = 0; i < 64; i++) begin
      src_val[i]  = '0;
      coef_val[i] = '0;
    end
    for (int i = 0; i < NUM_IN; i++) src_val[i] = in_q[i*DATA_W +: DATA_W];
    for (int n = 1; n <= NUM_NODES; n++) src_val[node_idx(n)] = node_q[n];
    for (int i = 0; i < NUM_COEF; i++) coef_val[i] = coef[i*DATA_W +: DATA_W];
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    add_a = '0;
    add_b = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < NUM_MUL; i++) begin
        if (row.mul[i].en) begin
          mul_a[i*DATA_W +: DATA_W] = src_val[row.mul[i].src_a];
          mul_b[i*DATA_W +: DATA_W] = coef_val[row.mul[i].src_b];
        end
      end
      for (int i = 0; i < NUM_ADD; i++) begin
        if (row.add[i].en) begin
          add_a[i*DATA_W +: DATA_W] = src_val[row.add[i].src_a];
          add_b[i*DATA_W +: DATA_W] = src_val[row.add[i].src_b];
        end
      end
    end
  end

  // Later writers override earlier ones, so a duplicate dst resolves to the
  // highest-indexed adder, then multiplier
  always_comb begin
    node_d = node_q;
    if (run_adv) begin
      for (int i = 0; i < NUM_MUL; i++) begin
        if (row.mul[i].en && row.mul[i].dst != 5'd0 && int'(row.mul[i].dst) <= NUM_NODES)
          node_d[row.mul[i].dst] = mul_res[i*DATA_W +: DATA_W];
      end
      for (int i = 0; i < NUM_ADD; i++) begin
        if (row.add[i].en && row.add[i].dst != 5'd0 && int'(row.add[i].dst) <= NUM_NODES)
          node_d[row.add[i].dst] = add_res[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs take the post-write node view so a final-step write is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      in_q   <= '0;
      out_27 <= '0;
      out_28 <= '0;
      for (int n = 1; n <= NUM_NODES; n++) node_q[n] <= '0;
    end else if (state_q == IDLE && start) begin
      step_q <= '0;
      in_q   <= in_data;
    end else if (run_adv) begin
      node_q <= node_d;
      step_q <= last_step ? '0 : step_q + 1'b1;
      if (last_step) begin
        out_27 <= node_d[27];
        out_28 <= node_d[28];
      end
    end
  end

endmodule

// File: tb/tb_arf_sched_ctrl.sv
// Directed bench for arf_sched_ctrl: models the shared units and the ARF
// graph, and checks latency, hold, start filtering and reset abort.
module tb_arf_sched_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          hold;
  logic [159:0]  in_data;
  logic [255:0]  coef;
  logic [31:0]   mul_a, mul_b, mul_res;
  logic [31:0]   add_a, add_b, add_res;
  logic [15:0]   out_27, out_28;
  logic          busy, done;

  int compared   = 0;
  int mismatched = 0;

  arf_sched_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hold    (hold),
    .in_data (in_data),
    .coef    (coef),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_res (mul_res),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_res (add_res),
    .out_27  (out_27),
    .out_28  (out_28),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Shared arithmetic units, modulo 2^16
  assign mul_res[15:0]  = mul_a[15:0]  * mul_b[15:0];
  assign mul_res[31:16] = mul_a[31:16] * mul_b[31:16];
  assign add_res[15:0]  = add_a[15:0]  + add_b[15:0];
  assign add_res[31:16] = add_a[31:16] + add_b[31:16];

  // Reference ARF graph evaluated directly, independent of any schedule
  function automatic logic [31:0] model(input logic [159:0] din, input logic [255:0] cf);
    logic [15:0] s [10];
    logic [15:0] c [16];
    logic [15:0] n [29];
    for (int i = 0; i < 10; i++) s[i] = din[i*16 +: 16];
    for (int i = 0; i < 16; i++) c[i] = cf[i*16 +: 16];
    for (int i = 0; i < 29; i++) n[i] = '0;
    for (int k = 1; k <= 8; k++) n[k] = s[k-1] * c[k-1];
    n[9]  = n[1] + n[2];
    n[10] = n[3] + n[4];
    n[11] = n[5] + n[6];
    n[12] = n[7] + n[8];
    n[13] = n[9] + s[8];
    n[14] = n[10] + s[9];
    n[15] = n[13] * c[8];
    n[16] = n[13] * c[9];
    n[17] = n[14] * c[10];
    n[18] = n[14] * c[11];
    n[19] = n[15] + n[17];
    n[20] = n[16] + n[18];
    n[21] = n[19] * c[12];
    n[22] = n[19] * c[13];
    n[23] = n[20] * c[14];
    n[24] = n[20] * c[15];
    n[25] = n[21] + n[23];
    n[26] = n[22] + n[24];
    n[27] = n[25] + n[11];
    n[28] = n[26] + n[12];
    return {n[27], n[28]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an evaluation in the current cycle (cycle 0) and runs until done
  // or a 40-cycle bound; optional hold window and extra start pulses.
  task automatic applyStimulus(input int hold_at, input int hold_len, input int pulse_a,
                               input int pulse_b, input int exp_done,
                               input logic [15:0] e27, input logic [15:0] e28);
    int          done_at;
    logic [31:0] cap_ma, cap_mb, cap_aa, cap_ab;
    done_at = -1;
    cap_ma = '0; cap_mb = '0; cap_aa = '0; cap_ab = '0;
    start = 1'b1;
    hold  = 1'b0;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      tick();
      start = (c == pulse_a) || (c == pulse_b);
      hold  = (c >= hold_at) && (c < hold_at + hold_len);
      if (done) done_at = c;
      else      checkOutput("busy_run", {31'b0, busy}, 32'd1);
      if (hold_len > 0 && c == hold_at) begin
        cap_ma = mul_a; cap_mb = mul_b; cap_aa = add_a; cap_ab = add_b;
      end
      if (hold_len > 0 && c > hold_at && c <= hold_at + hold_len) begin
        checkOutput("hold_mul_a", mul_a, cap_ma);
        checkOutput("hold_mul_b", mul_b, cap_mb);
        checkOutput("hold_add_a", add_a, cap_aa);
        checkOutput("hold_add_b", add_b, cap_ab);
      end
    end
    hold = 1'b0;
    checkOutput("done_cycle", 32'(done_at), 32'(exp_done));
    checkOutput("out_27", {16'b0, out_27}, {16'b0, e27});
    checkOutput("out_28", {16'b0, out_28}, {16'b0, e28});
  endtask

  initial begin
    logic [31:0] exp_pair;
    int          done_seen;
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    in_data = '0; coef = '0;
    repeat (2) tick();
    rst = 1'b0;

    $display("[TB] idle after reset");
    repeat (20) tick();
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    checkOutput("idle_done", {31'b0, done}, 32'd0);
    checkOutput("idle_out_27", {16'b0, out_27}, 32'd0);
    checkOutput("idle_out_28", {16'b0, out_28}, 32'd0);
    checkOutput("idle_mul_a", mul_a, 32'd0);
    checkOutput("idle_mul_b", mul_b, 32'd0);
    checkOutput("idle_add_a", add_a, 32'd0);
    checkOutput("idle_add_b", add_b, 32'd0);

    $display("[TB] zero inputs, unit coefficients");
    for (int i = 0; i < 16; i++) coef[i*16 +: 16] = 16'd1;
    applyStimulus(0, 0, -1, -1, 13, 16'd0, 16'd0);
    tick();
    checkOutput("done_single", {31'b0, done}, 32'd0);

    $display("[TB] inputs 1..10, unit coefficients");
    for (int i = 0; i < 10; i++) in_data[i*16 +: 16] = 16'(i + 1);
    applyStimulus(0, 0, -1, -1, 13, 16'd69, 16'd73);
    tick();

    $display("[TB] same inputs with a 3-cycle hold at step 4");
    applyStimulus(5, 3, -1, -1, 16, 16'd69, 16'd73);
    tick();

    $display("[TB] extra start pulses while busy and in DONE");
    applyStimulus(0, 0, 3, 13, 13, 16'd69, 16'd73);
    for (int i = 0; i < 10; i++) in_data[i*16 +: 16] = 16'(16'h0100 * (i + 1) + i);
    for (int i = 0; i < 16; i++) coef[i*16 +: 16] = 16'(i + 2);
    exp_pair = model(in_data, coef);
    tick();
    checkOutput("done_single_pulse", {31'b0, done}, 32'd0);
    applyStimulus(0, 0, -1, -1, 13, exp_pair[31:16], exp_pair[15:0]);
    tick();

    $display("[TB] reset abort at step 6");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_out_27", {16'b0, out_27}, 32'd0);
    checkOutput("rst_out_28", {16'b0, out_28}, 32'd0);
    checkOutput("rst_mul_a", mul_a, 32'd0);
    checkOutput("rst_add_a", add_a, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) done_seen++;
    end
    checkOutput("rst_no_done", 32'(done_seen), 32'd0);

    $display("[TB] fresh run with wrapping values");
    for (int i = 0; i < 10; i++) in_data[i*16 +: 16] = 16'(16'hF00D ^ (16'h1111 * i));
    for (int i = 0; i < 16; i++) coef[i*16 +: 16] = 16'(16'h8001 + 16'h0203 * i);
    exp_pair = model(in_data, coef);
    applyStimulus(0, 0, -1, -1, 13, exp_pair[31:16], exp_pair[15:0]);
    tick();
    checkOutput("final_idle_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
